// File: rtl/transpuesta_ctrl.sv
// Sequencing controller for the DCT transpose buffer: loads DEPTH rows, then unloads DEPTH columns.
// Define TRANSPUESTA_CTRL_PERF_EN to add the perf_blocks / perf_stall counters.
module transpuesta_ctrl #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned CW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          abort,
    input  logic          in_valid,
    input  logic          in_last,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_first,
    output logic          out_last,
    output logic          load,
    output logic          unload,
    output logic [CW-1:0] row_idx,
    output logic [CW-1:0] col_idx,
    output logic          busy,
    output logic          blk_done,
    output logic          err
`ifdef TRANSPUESTA_CTRL_PERF_EN
    ,
    output logic [31:0]   perf_blocks,
    output logic [31:0]   perf_stall
`endif
);

    localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        UNLOAD = 2'd2
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] row_n;
    logic [CW-1:0] col_n;
    logic          err_n;
    logic          done_n;

    // Buffer strobes; abort suppresses both in the cycle it is asserted.
    assign load   = in_valid & in_ready & ~abort;
    assign unload = out_valid & out_ready & ~abort;

    // Next-state, index and status computation.
    always_comb begin
        state_n = state;
        row_n   = row_idx;
        col_n   = col_idx;
        err_n   = err;
        done_n  = 1'b0;

        if (load && (in_last != (row_idx == LAST_IDX))) begin
            err_n = 1'b1;
        end

        if (abort && (state != IDLE)) begin
            state_n = en ? LOAD : IDLE;
            row_n   = '0;
            col_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        state_n = LOAD;
                    end
                end
                LOAD: begin
                    if (load) begin
                        if (row_idx == LAST_IDX) begin
                            row_n   = '0;
                            state_n = UNLOAD;
                        end else begin
                            row_n = row_idx + CW'(1);
                        end
                    end
                end
                UNLOAD: begin
                    if (unload) begin
                        if (col_idx == LAST_IDX) begin
                            col_n   = '0;
                            done_n  = 1'b1;
                            state_n = en ? LOAD : IDLE;
                        end else begin
                            col_n = col_idx + CW'(1);
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // State, indices and state-decoded outputs all come straight from flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            row_idx   <= '0;
            col_idx   <= '0;
            err       <= 1'b0;
            blk_done  <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            row_idx   <= row_n;
            col_idx   <= col_n;
            err       <= err_n;
            blk_done  <= done_n;
            in_ready  <= (state_n == LOAD);
            out_valid <= (state_n == UNLOAD);
            out_first <= (state_n == UNLOAD) && (col_n == '0);
            out_last  <= (state_n == UNLOAD) && (col_n == LAST_IDX);
            busy      <= (state_n != IDLE);
        end
    end

`ifdef TRANSPUESTA_CTRL_PERF_EN
    // Saturating block and column-stall counters; abort leaves them untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_blocks <= '0;
            perf_stall  <= '0;
        end else begin
            if (blk_done && (perf_blocks != '1)) begin
                perf_blocks <= perf_blocks + 32'd1;
            end
            if (out_valid && !out_ready && (perf_stall != '1)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_transpuesta_ctrl.sv
// Self-checking bench for transpuesta_ctrl: scoreboarded column sequence plus per-scenario checks.
module tb_transpuesta_ctrl;

    localparam int DEPTH       = 32;
    localparam int CW          = 5;
    localparam int MODE_OK     = -1;
    localparam int MODE_NOLAST = 1000;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          abort;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic          out_first;
    logic          out_last;
    logic          load;
    logic          unload;
    logic [CW-1:0] row_idx;
    logic [CW-1:0] col_idx;
    logic          busy;
    logic          blk_done;
    logic          err;
`ifdef TRANSPUESTA_CTRL_PERF_EN
    logic [31:0]   perf_blocks;
    logic [31:0]   perf_stall;
    int            blocks_model = 0;
    int            stall_model  = 0;
`endif

    typedef struct packed {
        logic [CW-1:0] col;
        logic          first;
        logic          last;
    } col_t;

    col_t exp_q[$];

    int checks = 0;
    int errors = 0;
    bit err_model = 1'b0;

    int n_load, n_unload, first_cyc, last_cyc, done_cyc, ov_cyc, ov_start;

    transpuesta_ctrl #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_first (out_first),
        .out_last  (out_last),
        .load      (load),
        .unload    (unload),
        .row_idx   (row_idx),
        .col_idx   (col_idx),
        .busy      (busy),
        .blk_done  (blk_done),
        .err       (err)
`ifdef TRANSPUESTA_CTRL_PERF_EN
        ,
        .perf_blocks (perf_blocks),
        .perf_stall  (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    // Runs one full block from LOAD with row 0; the column scoreboard is filled on the DEPTH-th load.
    task automatic run_block(input bit bp, input int last_mode, input int en_drop);
        bit   uphase    = 1'b0;
        bit   exp_rdy   = 1'b1;
        bit   done_pend = 1'b0;
        bit   done_next;
        bit   finished  = 1'b0;
        bit   do_load;
        bit   do_unl;
        int   loaded    = 0;
        int   ucnt      = 0;
        col_t e;
        exp_q.delete();
        n_load = 0; n_unload = 0; first_cyc = 0; last_cyc = 0;
        done_cyc = 0; ov_cyc = 0; ov_start = 0;
        for (int c = 1; c <= 400 && !finished; c++) begin
            en        = !(en_drop >= 0 && loaded >= en_drop);
            abort     = 1'b0;
            in_valid  = (loaded < DEPTH);
            in_last   = (last_mode == MODE_NOLAST) ? 1'b0
                      : ((loaded == DEPTH - 1) || (loaded == last_mode));
            out_ready = bp ? (ucnt % 2 == 0) : 1'b1;
            #1;
            do_load = exp_rdy && in_valid;
            do_unl  = uphase && out_ready;
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++; $display("FAIL in_ready cyc %0d: got %b expected %b", c, in_ready, exp_rdy);
            end
            checks++;
            if (load !== do_load) begin
                errors++; $display("FAIL load cyc %0d: got %b expected %b", c, load, do_load);
            end
            checks++;
            if (out_valid !== uphase) begin
                errors++; $display("FAIL out_valid cyc %0d: got %b expected %b", c, out_valid, uphase);
            end
            checks++;
            if (unload !== do_unl) begin
                errors++; $display("FAIL unload cyc %0d: got %b expected %b", c, unload, do_unl);
            end
            checks++;
            if (blk_done !== done_pend) begin
                errors++; $display("FAIL blk_done cyc %0d: got %b expected %b", c, blk_done, done_pend);
            end
            checks++;
            if (err !== err_model) begin
                errors++; $display("FAIL err cyc %0d: got %b expected %b", c, err, err_model);
            end
            checks++;
            if (row_idx !== CW'(loaded)) begin
                errors++; $display("FAIL row_idx cyc %0d: got %0d expected %0d", c, row_idx, CW'(loaded));
            end
            if (uphase) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL scoreboard cyc %0d: got column while queue empty", c);
                    finished = 1'b1;
                end else if ({col_idx, out_first, out_last} !==
                             {exp_q[0].col, exp_q[0].first, exp_q[0].last}) begin
                    errors++;
                    $display("FAIL column cyc %0d: got col %0d first %b last %b expected col %0d first %b last %b",
                             c, col_idx, out_first, out_last, exp_q[0].col, exp_q[0].first, exp_q[0].last);
                end
            end
            if (out_valid === 1'b1) begin
                ov_cyc++;
                if (ov_start == 0) ov_start = c;
            end
            if (out_first === 1'b1 && first_cyc == 0) first_cyc = c;
            if (load === 1'b1) n_load++;
            if (unload === 1'b1) begin
                n_unload++;
                if (out_last === 1'b1) last_cyc = c;
            end
            if (blk_done === 1'b1 && done_cyc == 0) done_cyc = c;
`ifdef TRANSPUESTA_CTRL_PERF_EN
            if (uphase && !out_ready) stall_model++;
`endif
            if (uphase) ucnt++;
            done_next = 1'b0;
            if (do_load) begin
                if (in_last != (loaded == DEPTH - 1)) err_model = 1'b1;
                if (loaded == DEPTH - 1) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        e.col   = CW'(i);
                        e.first = (i == 0);
                        e.last  = (i == DEPTH - 1);
                        exp_q.push_back(e);
                    end
                    exp_rdy = 1'b0;
                    uphase  = 1'b1;
                end
                loaded++;
            end else if (do_unl && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (e.last) begin
                    uphase    = 1'b0;
                    done_next = 1'b1;
                    exp_rdy   = en;
                end
            end
            if (done_pend) begin
                finished = 1'b1;
`ifdef TRANSPUESTA_CTRL_PERF_EN
                blocks_model++;
`endif
            end
            done_pend = done_next;
            advance();
        end
        checks++;
        if (done_cyc == 0) begin
            errors++; $display("FAIL block_timeout: got no blk_done expected one within budget");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; abort = 1'b0;
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, out_first, out_last, load, unload, busy, blk_done, err} !== 9'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0",
                     {in_ready, out_valid, out_first, out_last, load, unload, busy, blk_done, err});
        end
        checks++;
        if (row_idx !== '0 || col_idx !== '0) begin
            errors++; $display("FAIL reset_idx: got row %0d col %0d expected 0 0", row_idx, col_idx);
        end
`ifdef TRANSPUESTA_CTRL_PERF_EN
        checks++;
        if (perf_blocks !== 32'd0 || perf_stall !== 32'd0) begin
            errors++; $display("FAIL reset_perf: got %0d %0d expected 0 0", perf_blocks, perf_stall);
        end
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        advance();
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL idle_hold: got busy %b in_ready %b expected 0 0", busy, in_ready);
        end
    endtask

    task automatic test_basic();
        en = 1'b1;
        advance();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL idle_to_load: got in_ready %b busy %b expected 1 1", in_ready, busy);
        end
        run_block(1'b0, MODE_OK, -1);
        checks++;
        if (n_load != 32) begin errors++; $display("FAIL basic_loads: got %0d expected 32", n_load); end
        checks++;
        if (ov_cyc != 32) begin errors++; $display("FAIL basic_valid_cycles: got %0d expected 32", ov_cyc); end
        checks++;
        if (first_cyc != 33) begin errors++; $display("FAIL basic_first: got %0d expected 33", first_cyc); end
        checks++;
        if (last_cyc != 64) begin errors++; $display("FAIL basic_last: got %0d expected 64", last_cyc); end
        checks++;
        if (done_cyc != 65) begin errors++; $display("FAIL basic_done: got %0d expected 65", done_cyc); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b expected 0", err); end
`ifdef TRANSPUESTA_CTRL_PERF_EN
        checks++;
        if (perf_blocks !== 32'(blocks_model)) begin
            errors++; $display("FAIL basic_perf_blocks: got %0d expected %0d", perf_blocks, blocks_model);
        end
`endif
    endtask

    task automatic test_backpressure();
        run_block(1'b1, MODE_OK, -1);
        checks++;
        if (n_unload != 32) begin errors++; $display("FAIL bp_unloads: got %0d expected 32", n_unload); end
        checks++;
        if (ov_start != 33) begin errors++; $display("FAIL bp_start: got %0d expected 33", ov_start); end
        checks++;
        if (last_cyc - ov_start + 1 != 63) begin
            errors++; $display("FAIL bp_span: got %0d expected 63", last_cyc - ov_start + 1);
        end
        checks++;
        if (done_cyc != 96) begin errors++; $display("FAIL bp_done: got %0d expected 96", done_cyc); end
`ifdef TRANSPUESTA_CTRL_PERF_EN
        checks++;
        if (perf_stall !== 32'(stall_model) || stall_model != 31) begin
            errors++; $display("FAIL bp_perf_stall: got %0d expected %0d (31)", perf_stall, stall_model);
        end
`endif
    endtask

    task automatic test_abort();
        en = 1'b1; abort = 1'b0; out_ready = 1'b1;
        for (int r = 0; r < DEPTH; r++) begin
            in_valid = 1'b1;
            in_last  = (r == DEPTH - 1);
            advance();
        end
        in_valid = 1'b0; in_last = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || col_idx !== '0 || out_first !== 1'b1) begin
            errors++; $display("FAIL abort_unload_start: got valid %b col %0d first %b expected 1 0 1",
                               out_valid, col_idx, out_first);
        end
        repeat (5) advance();
        checks++;
        if (col_idx !== CW'(5)) begin errors++; $display("FAIL abort_col5: got %0d expected 5", col_idx); end
        abort = 1'b1;
        #1;
        checks++;
        if (load !== 1'b0 || unload !== 1'b0) begin
            errors++; $display("FAIL abort_strobes: got load %b unload %b expected 0 0", load, unload);
        end
        advance();
        abort = 1'b0;
        checks++;
        if ({in_ready, out_valid, blk_done, busy} !== 4'b1001 || row_idx !== '0 || col_idx !== '0) begin
            errors++; $display("FAIL abort_next: got rdy/val/done/busy %b row %0d col %0d expected 1001 0 0",
                               {in_ready, out_valid, blk_done, busy}, row_idx, col_idx);
        end
        advance();
        checks++;
        if (blk_done !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b expected 0", blk_done); end
`ifdef TRANSPUESTA_CTRL_PERF_EN
        checks++;
        if (perf_blocks !== 32'(blocks_model)) begin
            errors++; $display("FAIL abort_perf_blocks: got %0d expected %0d", perf_blocks, blocks_model);
        end
`endif
    endtask

    task automatic test_err_early();
        run_block(1'b0, 10, -1);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_early: got %b expected 1", err); end
        checks++;
        if (first_cyc != 33 || n_load != 32) begin
            errors++; $display("FAIL err_early_seq: got first %0d loads %0d expected 33 32", first_cyc, n_load);
        end
        repeat (3) advance();
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", err); end
    endtask

    task automatic test_err_missing_last();
        #2 rst = 1'b0;
        advance();
        rst = 1'b1; en = 1'b1; in_valid = 1'b0;
        err_model = 1'b0;
`ifdef TRANSPUESTA_CTRL_PERF_EN
        blocks_model = 0; stall_model = 0;
`endif
        advance();
        checks++;
        if (err !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL err_cleared: got err %b in_ready %b expected 0 1", err, in_ready);
        end
        run_block(1'b0, MODE_NOLAST, -1);
        checks++;
        if (err !== 1'b1 || first_cyc != 33) begin
            errors++; $display("FAIL err_nolast: got err %b first %0d expected 1 33", err, first_cyc);
        end
    endtask

    task automatic test_en_drop();
        run_block(1'b0, MODE_OK, 7);
        checks++;
        if (n_load != 32 || n_unload != 32) begin
            errors++; $display("FAIL en_drop_counts: got %0d %0d expected 32 32", n_load, n_unload);
        end
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL en_drop_idle: got busy %b rdy %b val %b expected 0 0 0",
                               busy, in_ready, out_valid);
        end
        advance();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL en_drop_stay: got %b expected 0", busy); end
    endtask

    task automatic test_async_reset();
        en = 1'b1;
        advance();
        in_valid = 1'b1; in_last = 1'b0;
        repeat (12) advance();
        checks++;
        if (row_idx !== CW'(12)) begin errors++; $display("FAIL ar_row12: got %0d expected 12", row_idx); end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, out_first, out_last, load, unload, busy, blk_done, err} !== 9'b0 ||
            row_idx !== '0 || col_idx !== '0) begin
            errors++; $display("FAIL ar_immediate: got flags %b row %0d col %0d expected 0",
                               {in_ready, out_valid, out_first, out_last, load, unload, busy, blk_done, err},
                               row_idx, col_idx);
        end
        advance();
        advance();
        rst = 1'b1; in_valid = 1'b0; en = 1'b1;
        err_model = 1'b0;
`ifdef TRANSPUESTA_CTRL_PERF_EN
        blocks_model = 0; stall_model = 0;
`endif
        advance();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL ar_restart: got %b expected 1", in_ready); end
        run_block(1'b0, MODE_OK, -1);
        checks++;
        if (n_load != 32 || done_cyc != 65 || err !== 1'b0) begin
            errors++; $display("FAIL ar_full_block: got loads %0d done %0d err %b expected 32 65 0",
                               n_load, done_cyc, err);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_abort();
        test_err_early();
        test_err_missing_last();
        test_en_drop();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/transpuesta_ctrl.md
Name: transpuesta_ctrl

Overview:
- Sequencing controller for the 32x32 transpose buffer that sits between the row (1st) and column (2nd) 1-D DCT passes.
- Accepts DEPTH row vectors from the row stage through a valid/ready handshake and drives the buffer's `load` strobe for each one.
- Then presents DEPTH column vectors to the column stage, driving `unload` on each accepted column.
- Tracks row/column indices, block boundaries and protocol errors.

Parameters:
- DEPTH, 32, rows per block = columns per block; power of two, 4..32.
- CW, $clog2(DEPTH), index counter width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  run enable; sampled at block boundaries only.
- abort  in  1  synchronous pulse; discards the current block.
- in_valid  in  1  row stage has a row vector on the buffer's x inputs.
- in_last  in  1  row stage marks its final row of the block.
- in_ready  out  1  controller accepts a row this cycle.
- out_valid  out  1  buffer y outputs hold a valid column.
- out_ready  in  1  column stage consumes the column.
- out_first  out  1  column 0 of the block presented.
- out_last  out  1  column DEPTH-1 presented.
- load  out  1  buffer load strobe, = in_valid & in_ready.
- unload  out  1  buffer unload strobe, = out_valid & out_ready.
- row_idx  out  CW  rows accepted so far in the current block.
- col_idx  out  CW  index of the column currently presented.
- busy  out  1  state != IDLE.
- blk_done  out  1  one-cycle pulse after the last column is accepted.
- err  out  1  sticky in_last protocol error.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; row_idx=0; col_idx=0; err=0; blk_done=0. All outputs low/zero. Release is synchronous to clk.
- States:
  - IDLE: in_ready=0, out_valid=0. Go to LOAD when en=1.
  - LOAD: in_ready=1, out_valid=0.
    - Each load increments row_idx.
    - A load with row_idx==DEPTH-1 clears row_idx and moves to UNLOAD on the next cycle.
  - UNLOAD: in_ready=0, out_valid=1. out_first=(col_idx==0); out_last=(col_idx==DEPTH-1).
    - Each unload increments col_idx.
    - The unload at col_idx==DEPTH-1 clears col_idx, pulses blk_done on the next cycle, and goes to LOAD if en=1, else IDLE.
- en deassert mid-block: the current block still completes fully; en is checked only at the UNLOAD exit and in IDLE.
- Latency:
  - Column 0 is valid the cycle after the DEPTH-th load; no bubble.
  - Minimum block period is 2*DEPTH cycles (64 at default).
- The first UNLOAD cycle shows buffer column 0 directly. Each unload shifts the next column into position, so the y outputs are already correct when out_valid rises.
- out_ready low holds out_valid, col_idx and the buffer unchanged; no timeout.
- in_last check:
  - in_last=1 on a load with row_idx!=DEPTH-1 sets err.
  - in_last=0 on the load with row_idx==DEPTH-1 also sets err.
  - Sequencing continues by count regardless. err clears only on reset.
- abort (highest priority, any state except IDLE):
  - Next state is LOAD if en=1, else IDLE; row_idx=0, col_idx=0; no blk_done.
  - load and unload are forced to 0 in the abort cycle.
  - Buffer contents are left stale and are overwritten by the next DEPTH loads.
- Simultaneous abort and last unload: abort wins, no blk_done.
- load and unload are never high in the same cycle.

Optional Feature:
- Macro: TRANSPUESTA_CTRL_PERF_EN.
- When defined, adds two output ports:
  - perf_blocks[31:0]: counts blk_done pulses.
  - perf_stall[31:0]: counts cycles with out_valid & ~out_ready.
  - Both reset to 0 with rst and saturate at 2^32-1; abort does not clear them.
- When undefined, these ports and counters are absent and all other behaviour is identical.

Test Plan:
- Basic block: en=1, in_valid held high, 32 rows with in_last on row 31, out_ready high -> 32 loads, then out_valid for exactly 32 cycles; out_first on cycle 33, out_last on cycle 64, blk_done on cycle 65, err=0.
- Column backpressure: out_ready toggling 1,0 during UNLOAD -> 32 unloads over 63 cycles, col_idx stable while out_ready=0, perf_stall=31 (with macro).
- Protocol errors: in_last on row 10 -> err=1 and remains 1; UNLOAD still starts after row 31. Separate run with in_last=0 on row 31 -> err=1.
- Abort mid-unload: abort at col_idx=5 -> next cycle state LOAD, row_idx=0, col_idx=0, no blk_done, perf_blocks unchanged.
- en drop mid-block: en=0 at row 7 -> block completes with 32 loads and 32 unloads, then IDLE with busy=0 and in_ready=0.
- Async reset mid-LOAD at row_idx=12: rst low between clock edges -> outputs zero immediately; after release, an en=1 block runs a full 32 rows.
